// File: rtl/frame_capture.sv
// Frame capture: writes a camera pixel stream into a linear frame memory.
// Define FRAME_CAPTURE_DECIMATE_EN to keep only even-x/even-y pixels.
module frame_capture #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    input  logic              pix_sof,
    input  logic              pix_eol,
    input  logic              frame_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        err
);
`ifdef FRAME_CAPTURE_DECIMATE_EN
    localparam int OUT_W = IMG_W / 2;
`else
    localparam int OUT_W = IMG_W;
`endif
    localparam int XW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [XW-1:0] X_FULL = XW'(IMG_W);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d, cur_x;
    logic [YW-1:0]     y_q, y_d, cur_y;
    logic [ADDR_W-1:0] base_q, base_d, cur_base, step, col_off;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              we_q, we_d, done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              take, restart, keep;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        base_d   = base_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        err_d    = err_q;
        take     = 1'b0;
        restart  = 1'b0;
        cur_x    = x_q;
        cur_y    = y_q;
        cur_base = base_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_SOF;
                    err_d   = '0;
                end
            end
            WAIT_SOF: begin
                if (pix_valid && pix_sof) begin
                    take    = 1'b1;
                    restart = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (pix_valid) begin
                    take = 1'b1;
                    if (pix_sof) begin
                        restart  = 1'b1;
                        err_d[1] = 1'b1;
                    end
                end
            end
            DONE: begin
                if (frame_ack && done_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (restart) begin
            cur_x    = '0;
            cur_y    = '0;
            cur_base = '0;
        end

        // Line base advances by one output row; decimation skips odd rows.
`ifdef FRAME_CAPTURE_DECIMATE_EN
        keep    = (cur_x < X_FULL) && !cur_x[0] && !cur_y[0];
        step    = cur_y[0] ? ADDR_W'(OUT_W) : '0;
        col_off = ADDR_W'(cur_x >> 1);
`else
        keep    = cur_x < X_FULL;
        step    = ADDR_W'(OUT_W);
        col_off = ADDR_W'(cur_x);
`endif

        if (take) begin
            if (keep) begin
                we_d    = 1'b1;
                addr_d  = cur_base + col_off;
                wdata_d = pix_data;
            end
            if (pix_eol) begin
                if (cur_x < X_LAST) err_d[0] = 1'b1;
                x_d    = '0;
                y_d    = cur_y + YW'(1);
                base_d = cur_base + step;
                if (cur_y == Y_LAST) state_d = DONE;
            end else begin
                // Saturate past the last column so overlong lines drop pixels.
                if (cur_x == X_LAST) err_d[0] = 1'b1;
                x_d = (cur_x == X_FULL) ? cur_x : cur_x + XW'(1);
                y_d = cur_y;
                base_d = cur_base;
            end
        end

        done_d = (state_q == DONE) && (state_d == DONE);
    end

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q == WAIT_SOF) || (state_q == CAPTURE);
    assign frame_done = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: per-cycle reference model plus directed frames.
module tb_frame_capture;
    localparam int W  = 4;
`ifdef FRAME_CAPTURE_DECIMATE_EN
    localparam int H  = 4;
    localparam bit DEC = 1'b1;
`else
    localparam int H  = 2;
    localparam bit DEC = 1'b0;
`endif
    localparam int AW = 8;
    localparam int OW = DEC ? W / 2 : W;

    logic          clk, rst, start, pix_valid, pix_sof, pix_eol, frame_ack;
    logic [7:0]    pix_data;
    logic          mem_we, busy, frame_done;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [1:0]    err;

    frame_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol),
        .frame_ack(frame_ack), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .frame_done(frame_done),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int bad  = 0;
    logic [15:0] log_q[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Reference model: modes 0 idle, 1 wait-sof, 2 capture, 3 done.
    int         m_mode, m_col, m_line, e_addr, e_data;
    logic       e_we, e_done;
    logic [1:0] e_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_col = 0; m_line = 0;
            e_we = 0; e_done = 0; e_err = 0; e_addr = 0; e_data = 0;
        end else begin
            e_we = 0;
            case (m_mode)
                0: if (start) begin m_mode = 1; e_err = 0; end
                1, 2: if (pix_valid) begin
                    if (pix_sof) begin
                        if (m_mode == 2) e_err[1] = 1'b1;
                        m_mode = 2; m_col = 0; m_line = 0;
                    end
                    if (m_mode == 2) begin
                        if (m_col < W && (!DEC || (m_col % 2 == 0 && m_line % 2 == 0))) begin
                            e_we   = 1;
                            e_addr = DEC ? (m_line / 2) * OW + m_col / 2
                                         : m_line * OW + m_col;
                            e_data = pix_data;
                        end
                        if (pix_eol) begin
                            if (m_col < W - 1) e_err[0] = 1'b1;
                            m_col = 0;
                            m_line++;
                            if (m_line == H) m_mode = 3;
                        end else begin
                            if (m_col >= W - 1) e_err[0] = 1'b1;
                            m_col++;
                        end
                    end
                end
                3: if (frame_ack && e_done) begin m_mode = 0; e_done = 0; end
                   else e_done = 1;
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("we", mem_we, e_we);
            chk("busy", busy, (m_mode == 1 || m_mode == 2));
            chk("frame_done", frame_done, e_done);
            chk("err", err, e_err);
            if (e_we) begin
                chk("addr", mem_addr, e_addr);
                chk("wdata", mem_wdata, e_data);
            end
            if (mem_we) log_q.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] d, input logic s, input logic e);
        pix_valid = 1; pix_data = d; pix_sof = s; pix_eol = e;
        tick();
        pix_valid = 0; pix_sof = 0; pix_eol = 0;
    endtask

    task automatic go();
        start = 1; tick(); start = 0;
        log_q.delete();
    endtask

    task automatic ack();
        frame_ack = 1; tick(); frame_ack = 0;
    endtask

    task automatic chk_w(input string n, input int i, input int a, input int d);
        logic [15:0] ent;
        ent = (i < log_q.size()) ? log_q[i] : 16'hxxxx;
        chk({n, "_addr"}, ent[15:8], a);
        chk({n, "_data"}, ent[7:0], d);
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_we"}, mem_we, 0);
        chk({n, "_addr"}, mem_addr, 0);
        chk({n, "_wdata"}, mem_wdata, 0);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_done"}, frame_done, 0);
        chk({n, "_err"}, err, 0);
    endtask

    initial begin
        rst = 1; start = 0; pix_valid = 0; pix_sof = 0; pix_eol = 0;
        frame_ack = 0; pix_data = 0;
        #2;
        chk_zero("reset");
        tick(); tick();
        rst = 0;
        tick();

`ifdef FRAME_CAPTURE_DECIMATE_EN
        go();
        for (int i = 0; i < 16; i++) pix(8'(i), i == 0, i % 4 == 3);
        tick();
        chk("dec_count", log_q.size(), 4);
        chk_w("dec0", 0, 0, 0);
        chk_w("dec1", 1, 1, 2);
        chk_w("dec2", 2, 2, 8);
        chk_w("dec3", 3, 3, 10);
        chk("dec_done", frame_done, 1);
        ack();
        chk("dec_ack", frame_done, 0);
`else
        // Full frame 0..7
        go();
        chk("busy_wait", busy, 1);
        for (int i = 0; i < 8; i++) pix(8'(i), i == 0, i % 4 == 3);
        chk("last_we", mem_we, 1);
        chk("last_addr", mem_addr, 7);
        chk("done_early", frame_done, 0);
        tick();
        chk("done_rise", frame_done, 1);
        chk("done_we", mem_we, 0);
        chk("frame_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++) chk_w("full", i, i, i);
        tick();
        ack();
        chk("done_ack", frame_done, 0);

        // Pixels before SOF are discarded
        go();
        pix(8'hAA, 0, 0);
        pix(8'hBB, 0, 1);
        tick();
        chk("presof_none", log_q.size(), 0);
        pix(8'h10, 1, 0);
        tick();
        chk_w("sof_first", 0, 0, 8'h10);
        pix(8'h11, 0, 0); pix(8'h12, 0, 0); pix(8'h13, 0, 1);
        for (int i = 4; i < 8; i++) pix(8'(8'h10 + i), 0, i == 7);
        tick();
        chk("sof_err", err, 0);
        ack();

        // Short line 0
        go();
        pix(8'h20, 1, 0);
        pix(8'h21, 0, 1);
        chk("short_err", err, 2'b01);
        for (int i = 0; i < 4; i++) pix(8'(8'h30 + i), 0, i == 3);
        tick();
        chk("short_count", log_q.size(), 6);
        chk_w("short_l0", 1, 1, 8'h21);
        for (int i = 0; i < 4; i++) chk_w("short_l1", 2 + i, 4 + i, 8'h30 + i);
        ack();

        // SOF mid-frame restarts at address 0
        go();
        chk("err_clear", err, 0);
        for (int i = 0; i < 4; i++) pix(8'(8'h60 + i), i == 0, i == 3);
        pix(8'h64, 0, 0);
        pix(8'h65, 0, 0);
        pix(8'h55, 1, 0);
        chk("resof_err", err, 2'b10);
        chk("resof_we", mem_we, 1);
        chk("resof_addr", mem_addr, 0);
        chk("resof_data", mem_wdata, 8'h55);
        pix(8'h56, 0, 0); pix(8'h57, 0, 0); pix(8'h58, 0, 1);
        for (int i = 0; i < 4; i++) pix(8'(8'h59 + i), 0, i == 3);
        chk("resof_end", mem_addr, 7);
        tick();
        chk("resof_done", frame_done, 1);
        ack();

        // Long line 0: extra pixels dropped
        go();
        for (int i = 0; i < 6; i++) pix(8'(8'h70 + i), i == 0, i == 5);
        tick();
        chk("long_err", err, 2'b01);
        chk("long_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) pix(8'(8'h80 + i), 0, i == 3);
        tick();
        for (int i = 0; i < 4; i++) chk_w("long_l1", 4 + i, 4 + i, 8'h80 + i);
        ack();

        // Asynchronous reset mid-line
        go();
        pix(8'h40, 1, 0);
        pix(8'h41, 0, 0);
        #2 rst = 1;
        #1 chk_zero("midrst");
        tick();
        tick();
        rst = 0;
        log_q.delete();
        pix(8'h50, 1, 0);
        pix(8'h51, 0, 1);
        tick();
        chk("post_rst_none", log_q.size(), 0);
        chk("post_rst_busy", busy, 0);
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, bad);
        $finish;
    end
endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter IMG_W, default 320, meaning input pixels per line.
REQ-002 SHALL have parameter IMG_H, default 240, meaning input lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 17, meaning frame-memory address width.
REQ-004 SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, controller request to capture one frame.
REQ-007 SHALL have port pix_valid, input, 1, camera pixel qualifier.
REQ-008 SHALL have port pix_data, input, 8, grayscale pixel.
REQ-009 SHALL have port pix_sof, input, 1, first pixel of frame; valid only with pix_valid.
REQ-010 SHALL have port pix_eol, input, 1, last pixel of line; valid only with pix_valid.
REQ-011 SHALL have port frame_ack, input, 1, controller has consumed the frame.
REQ-012 SHALL have port mem_we, output, 1, frame-memory write strobe.
REQ-013 SHALL have port mem_addr, output, ADDR_W, write address.
REQ-014 SHALL have port mem_wdata, output, 8, write data.
REQ-015 SHALL have port busy, output, 1, high in WAIT_SOF and CAPTURE.
REQ-016 SHALL have port frame_done, output, 1, complete frame in memory.
REQ-017 SHALL have port err, output, 2, sticky flags: bit0 line-length error, bit1 unexpected SOF.

Function
REQ-018 SHALL implement states IDLE, WAIT_SOF, CAPTURE, DONE.
REQ-019 IDLE -> WAIT_SOF when start=1; start SHALL be ignored in all other states.
REQ-020 WAIT_SOF: pixels without pix_sof SHALL be discarded; pix_valid&pix_sof -> CAPTURE, that pixel written at x=0,y=0.
REQ-021 CAPTURE: each accepted pixel SHALL produce mem_we=1 exactly one cycle later, mem_addr=y*OUT_W+x, mem_wdata=registered pix_data; address computed incrementally, no multiplier.
REQ-022 x SHALL increment per accepted pixel; on pix_eol x SHALL clear and y increment.
REQ-023 Short line (pix_eol with x<IMG_W-1): SHALL set err[0], advance to next line base address; missing pixels not written.
REQ-024 Long line (x=IMG_W-1 reached without pix_eol): further pixels SHALL be dropped (no mem_we) until pix_eol; err[0] set.
REQ-025 pix_sof in CAPTURE SHALL set err[1] and restart the frame at x=0,y=0 with that pixel written to address 0.
REQ-026 pix_eol on line IMG_H-1 SHALL move to DONE; frame_done rises the cycle after the final mem_we.
REQ-027 DONE: frame_done held high, no writes; frame_ack=1 -> IDLE, frame_done low next cycle.
REQ-028 err SHALL clear only on rst or on start accepted in IDLE.
REQ-029 pix_valid=0 cycles SHALL not alter x, y or address.

Reset
REQ-030 rst SHALL asynchronously force IDLE, x=y=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_done=0, err=0, including mid-frame.
REQ-031 After rst deassert, no write SHALL occur before the next start and pix_sof.

Configuration
REQ-032 With FRAME_CAPTURE_DECIMATE_EN defined, SHALL write only pixels with even x and even y; OUT_W=IMG_W/2, frame holds (IMG_W/2)*(IMG_H/2) pixels; line counting and errors still use full input geometry.
REQ-033 Without FRAME_CAPTURE_DECIMATE_EN, OUT_W=IMG_W and every in-range pixel SHALL be written.

Verification
REQ-034 IMG_W=4,IMG_H=2, start, full frame of data 0..7 -> writes addr 0..7 data 0..7, frame_done one cycle after last write, cleared after frame_ack.
REQ-035 Pixels before SOF in WAIT_SOF -> no mem_we; first write is SOF pixel at addr 0.
REQ-036 Line 0 eol after 2 pixels (IMG_W=4) -> err=01, line-1 pixels at addr 4..7.
REQ-037 pix_sof at y=1,x=2 -> err=10, that pixel written at addr 0, frame restarts.
REQ-038 rst asserted mid-line -> all outputs zero same cycle, state IDLE, subsequent pixels ignored.
REQ-039 Macro defined, IMG_W=4,IMG_H=4, data 0..15 -> four writes: addr0=0, addr1=2, addr2=8, addr3=10.
